// File: rtl/mmio_uart_tx_if.sv
// Core data-port bus for the memory-mapped UART transmitter.
// The core drives stores and addresses; the peripheral returns read data.
interface mmio_uart_tx_if;
   logic        WE;
   logic [31:0] A;
   logic [31:0] WD;
   logic [3:0]  strobe;
   logic [31:0] RD;

   modport master (output WE, output A, output WD, output strobe, input RD);
   modport slave  (input WE, input A, input WD, input strobe, output RD);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 16-byte register window (TXDATA, STATUS,
// CTRL), a small transmit FIFO and an 8N1 serializer with a registered line.
// The serial line is registered from the FSM state, so it lags the state by
// one cycle; a push into an idle, enabled transmitter drops tx two edges later.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic           clk,
   input  logic           rst,
   mmio_uart_tx_if.slave  bus,
   output logic           tx,
   output logic           busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CPB_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CPB_W-1:0] BIT_LAST   = CPB_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CPB_W-1:0] CYC_ONE    = CPB_W'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   // FSM / serializer state
   state_t           state_q;
   logic [CPB_W-1:0] cyc_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             tx_q;

   // FIFO and register state
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             ovf_q,    ovf_d;
   logic             en_q,     en_d;

   // Decoded bus controls
   logic       sel_s;
   logic [1:0] off_s;
   logic       wr_s;
   logic       push_s;
   logic       pop_s;
   logic       accept_s;
   logic       full_s;
   logic       empty_s;
   logic       clr_ovf_s;
   logic       ctrl_wr_s;
   logic [31:0] status_s;
   logic       unused_s;

   assign unused_s = ^{bus.WD[31:8], bus.strobe[3:1], bus.A[1:0]};

   // Address decode, FIFO handshake and status word
   always_comb begin
      sel_s     = (bus.A[31:4] == BASE_ADDR[31:4]);
      off_s     = bus.A[3:2];
      wr_s      = bus.WE & sel_s & bus.strobe[0];
      push_s    = wr_s & (off_s == 2'd0);
      clr_ovf_s = wr_s & (off_s == 2'd1) & bus.WD[3];
      ctrl_wr_s = wr_s & (off_s == 2'd2);
      full_s    = (count_q == CNT_FULL);
      empty_s   = (count_q == {CNT_W{1'b0}});
      // The transmitter pops when it leaves IDLE; a pop frees a slot this cycle.
      pop_s     = (state_q == IDLE) & en_q & ~empty_s;
      accept_s  = push_s & (~full_s | pop_s);
      busy      = (state_q != IDLE) | ~empty_s;
      status_s  = {24'd0, 4'(count_q), ovf_q, empty_s, full_s, busy};
   end

   // Read mux: combinational from address and register state
   always_comb begin
      bus.RD = 32'd0;
      if (sel_s) begin
         case (off_s)
            2'd0:    bus.RD = 32'd0;
            2'd1:    bus.RD = status_s;
            2'd2:    bus.RD = {31'd0, en_q};
            default: bus.RD = 32'd0;
         endcase
      end else begin
         bus.RD = 32'd0;
      end
   end

   // Next-state for FIFO pointers, occupancy, sticky overflow and enable
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      en_d     = en_q;
      if (accept_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({accept_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // A dropped push wins over a same-cycle clear so no overflow is lost.
      if (push_s & ~accept_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (ctrl_wr_s) begin
         en_d = bus.WD[0];
      end else begin
         en_d = en_q;
      end
   end

   // FIFO control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         ovf_q    <= 1'b0;
         en_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         en_q     <= en_d;
      end
   end

   // FIFO storage; contents are don't-care until written, writes blocked in reset
   always_ff @(posedge clk) begin
      if (rst && accept_s) begin
         mem_q[wr_ptr_q] <= bus.WD[7:0];
      end
   end

   // Transmit FSM with registered serial line (tx follows state one cycle later)
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cyc_q   <= {CPB_W{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop_s) begin
                  state_q <= START;
                  shift_q <= mem_q[rd_ptr_q];
                  cyc_q   <= {CPB_W{1'b0}};
                  bit_q   <= 3'd0;
               end else begin
                  state_q <= IDLE;
               end
            end
            START: begin
               if (cyc_q == BIT_LAST) begin
                  state_q <= DATA;
                  cyc_q   <= {CPB_W{1'b0}};
               end else begin
                  cyc_q   <= cyc_q + CYC_ONE;
               end
            end
            DATA: begin
               if (cyc_q == BIT_LAST) begin
                  cyc_q   <= {CPB_W{1'b0}};
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                     bit_q   <= 3'd0;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  cyc_q   <= cyc_q + CYC_ONE;
               end
            end
            STOP: begin
               if (cyc_q == BIT_LAST) begin
                  state_q <= IDLE;
                  cyc_q   <= {CPB_W{1'b0}};
               end else begin
                  cyc_q   <= cyc_q + CYC_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               cyc_q   <= {CPB_W{1'b0}};
            end
         endcase

         case (state_q)
            START:   tx_q <= 1'b0;
            DATA:    tx_q <= shift_q[0];
            default: tx_q <= 1'b1;
         endcase
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table followed by
// hand-written serial-frame sequences with a line monitor.
module tb_mmio_uart_tx;

   localparam int          CPB    = 16;
   localparam logic [31:0] BASE   = 32'h0000_1000;
   localparam logic [31:0] TXDATA = 32'h0000_1000;
   localparam logic [31:0] STATUS = 32'h0000_1004;
   localparam logic [31:0] CTRL   = 32'h0000_1008;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx;
   logic busy;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .tx   (tx),
      .busy (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      bus.WE = 1'b1; bus.A = a; bus.WD = d; bus.strobe = s;
      @(posedge clk); #1;
      bus.WE = 1'b0; bus.strobe = 4'h0;
   endtask

   task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      bus.WE = 1'b0; bus.A = a;
      #1;
      chk(nm, bus.RD, exp);
   endtask

   // Wait (bounded) for a start bit, then sample each bit mid-period.
   task automatic rx_frame(output logic [7:0] b, output int t0);
      int n;
      b = 8'h00; t0 = -1; n = 0;
      @(negedge clk);
      while (tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rx_start_seen", {31'd0, tx}, 32'd0);
      if (tx === 1'b0) begin
         t0 = cyc;
         repeat (CPB/2) @(negedge clk);
         chk("rx_start_bit", {31'd0, tx}, 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         chk("rx_stop_bit", {31'd0, tx}, 32'd1);
      end
   endtask

   initial begin
      logic [7:0] rb;
      int         t_prev, t_now, n0, lows;
      logic [7:0] exp_b [5];

      bus.WE = 1'b0; bus.A = 32'd0; bus.WD = 32'd0; bus.strobe = 4'h0;

      //              we    addr                wd          strb   exp_rd
      tbl[0]  = '{1'b0, STATUS,            32'h0,      4'h0,  32'h04};
      tbl[1]  = '{1'b0, CTRL,              32'h0,      4'h0,  32'h00};
      tbl[2]  = '{1'b1, BASE + 32'h20,     32'h55,     4'hF,  32'h00};
      tbl[3]  = '{1'b1, TXDATA,            32'h66,     4'hE,  32'h00};
      tbl[4]  = '{1'b0, STATUS,            32'h0,      4'h0,  32'h04};
      tbl[5]  = '{1'b1, TXDATA,            32'h01,     4'hF,  32'h00};
      tbl[6]  = '{1'b1, TXDATA,            32'h02,     4'hF,  32'h00};
      tbl[7]  = '{1'b1, TXDATA,            32'h03,     4'hF,  32'h00};
      tbl[8]  = '{1'b1, TXDATA,            32'h04,     4'hF,  32'h00};
      tbl[9]  = '{1'b1, TXDATA,            32'h09,     4'hF,  32'h00};
      tbl[10] = '{1'b0, STATUS,            32'h0,      4'h0,  32'h4B};
      tbl[11] = '{1'b1, STATUS,            32'h08,     4'hE,  32'h4B};
      tbl[12] = '{1'b0, STATUS,            32'h0,      4'h0,  32'h4B};
      tbl[13] = '{1'b1, STATUS,            32'h08,     4'h1,  32'h4B};
      tbl[14] = '{1'b0, STATUS,            32'h0,      4'h0,  32'h43};
      tbl[15] = '{1'b1, BASE + 32'hC,      32'hFF,     4'hF,  32'h00};
      tbl[16] = '{1'b0, BASE + 32'hC,      32'h0,      4'h0,  32'h00};
      tbl[17] = '{1'b0, 32'h0000_2004,     32'h0,      4'h0,  32'h00};
      tbl[18] = '{1'b0, CTRL,              32'h0,      4'h0,  32'h00};

      // Reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);

      // Register-access vectors (enable stays 0, FIFO fills with 01..04)
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         bus.WE = tbl[i].we; bus.A = tbl[i].a; bus.WD = tbl[i].wd; bus.strobe = tbl[i].strb;
         #1;
         chk($sformatf("vec%0d_rd", i), bus.RD, tbl[i].exp_rd);
         @(posedge clk); #1;
         bus.WE = 1'b0; bus.strobe = 4'h0;
      end

      // Enable, then push into the full FIFO on the same edge as the first pop
      bus_wr(CTRL, 32'h1, 4'h1);
      n0 = cyc;
      bus_wr(TXDATA, 32'h05, 4'hF);
      chk_rd("full_push_pop_status", STATUS, 32'h43);
      exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h04; exp_b[4] = 8'h05;
      t_prev = 0;
      for (int f = 0; f < 5; f++) begin
         rx_frame(rb, t_now);
         chk($sformatf("frame%0d_byte", f), {24'd0, rb}, {24'd0, exp_b[f]});
         if (f == 0) chk("first_start_latency", t_now - n0, 32'd2);
         else        chk($sformatf("frame%0d_spacing", f), t_now - t_prev, 32'd161);
         t_prev = t_now;
      end
      repeat (12) @(negedge clk);
      chk_rd("drained_status", STATUS, 32'h04);

      // Single 0xA5 frame; enable cleared mid-frame must not cut it short
      bus_wr(TXDATA, 32'hA5, 4'hF);
      n0 = cyc;
      fork
         rx_frame(rb, t_now);
         begin
            repeat (40) @(posedge clk);
            bus_wr(CTRL, 32'h0, 4'h1);
         end
      join
      chk("a5_latency", t_now - n0, 32'd2);
      chk("a5_byte", {24'd0, rb}, 32'hA5);
      while (cyc < n0 + 160) @(negedge clk);
      chk("a5_busy_in_stop", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("a5_busy_done", {31'd0, busy}, 32'd0);
      chk("a5_tx_idle", {31'd0, tx}, 32'd1);

      // Reset pulse in mid-DATA aborts the frame and discards queued bytes
      bus_wr(CTRL, 32'h1, 4'h1);
      bus_wr(TXDATA, 32'h3C, 4'hF);
      n0 = cyc;
      bus_wr(TXDATA, 32'h5A, 4'hF);
      while (cyc < n0 + 2 + CPB + 40) @(negedge clk);
      rst = 1'b0;
      bus.WE = 1'b1; bus.A = TXDATA; bus.WD = 32'hEE; bus.strobe = 4'hF;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.WE = 1'b0; bus.strobe = 4'h0;
      chk("abort_tx_high", {31'd0, tx}, 32'd1);
      chk_rd("abort_status", STATUS, 32'h04);
      chk_rd("abort_ctrl", CTRL, 32'h00);
      lows = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("abort_no_output", lows, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, base of the 16-byte register window; BASE_ADDR[3:0] is zero.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; minimum 2.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; a power of two, 2..8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 WE  input  1  store enable from the core's data port.
REQ-007 A  input  32  byte address from the core's data port.
REQ-008 WD  input  32  store data from the core's data port.
REQ-009 strobe  input  4  byte-lane enables; bit i qualifies WD[8i+7:8i].
REQ-010 RD  output  32  read data to the core; combinational from A and register state.
REQ-011 tx  output  1  serial line, registered, idle high.
REQ-012 busy  output  1  high when the FSM is outside IDLE or the FIFO is not empty.

Function
REQ-013 sel = (A[31:4] == BASE_ADDR[31:4]); offset = A[3:2]; no access has any effect when sel=0, and RD = 0 when sel=0.
REQ-014 Offset 0 TXDATA: WE & sel & strobe[0] pushes WD[7:0]; reads return 0.
REQ-015 Offset 1 STATUS, read-only except bit 3: [0] busy, [1] full, [2] empty, [3] overflow (sticky), [7:4] count, all other bits 0.
REQ-016 Writing offset 1 with strobe[0]=1 and WD[3]=1 clears overflow; other written bits are ignored.
REQ-017 Offset 2 CTRL: bit 0 enable; written when WE & sel & strobe[0]; reads return {31'b0, enable}.
REQ-018 Offset 3 reads 0 and ignores writes.
REQ-019 A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle; otherwise the data is dropped and overflow is set.
REQ-020 FIFO order: first in, first out; pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
REQ-021 FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE -> START when enable=1 and the FIFO is not empty; this transition pops one byte into a shift register.
REQ-023 START drives tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
REQ-024 DATA sends 8 bits LSB first, each bit for CLKS_PER_BIT cycles, then goes to STOP.
REQ-025 STOP drives tx=1 for CLKS_PER_BIT cycles, then goes to IDLE unconditionally.
REQ-026 A frame started with enable=1 completes even if enable is cleared mid-frame; clearing enable only blocks the next IDLE -> START.
REQ-027 Latency: a push at edge N into an empty FIFO with the FSM in IDLE and enable=1 makes tx fall at edge N+2.
REQ-028 Back-to-back frames: the falling edge of tx for each frame is 10*CLKS_PER_BIT+1 cycles after the previous one.
REQ-029 A simultaneous push and pop with the FIFO full is accepted, count stays FIFO_DEPTH, and overflow is not set.

Reset
REQ-030 On a rising edge with rst=0: FSM=IDLE, tx=1, FIFO empty (count=0, pointers 0), overflow=0, enable=0, bit and cycle counters 0.
REQ-031 rst=0 during a frame aborts it; tx=1 after that edge and queued bytes are discarded.
REQ-032 Bus writes during reset are ignored.

Verification
REQ-033 Reset, then write CTRL=1 and TXDATA=0xA5 (CLKS_PER_BIT=16) -> tx low at write edge+2; bits 1,0,1,0,0,1,0,1 at 16-cycle spacing; stop high; busy=0 after 161 cycles.
REQ-034 With enable=0, push 5 bytes (depth 4) -> STATUS reads 0x4B (count 4, overflow, full, busy); write STATUS WD=0x8 -> 0x43.
REQ-035 Enable with the FIFO holding 0x11, 0x22, 0x33 -> three frames in order, start edges 161 cycles apart, empty=1 at the end.
REQ-036 Store to BASE_ADDR+0x20 or with strobe=4'b1110 at TXDATA -> no push, RD=0 for the unmapped read, count unchanged.
REQ-037 rst=0 for one cycle in mid-DATA -> tx=1 next cycle, STATUS=0x04, no further frame output.
REQ-038 Push at the same edge as a pop with the FIFO full -> count remains 4, overflow=0, byte order preserved.
